// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: memory map, pc select encoding
// and the IF/ID pipeline register bundle.
package mips_pkg;

    localparam logic [31:0] TEXT_BASE = 32'h0000_3000;
    localparam logic [31:0] DATA_BASE = 32'h0000_0000;
    localparam logic [31:0] NOP       = 32'h0000_0000;

    typedef enum logic [1:0] {
        PC_SEQ    = 2'd0,
        PC_HOLD   = 2'd1,
        PC_JUMP   = 2'd2,
        PC_BRANCH = 2'd3
    } pc_sel_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        valid;
    } if_id_t;

endpackage

// File: rtl/pc_next_sel.sv
// Next-PC priority mux: EX branch over load-use stall over ID jump
// over sequential fetch.
module pc_next_sel
    import mips_pkg::*;
(
    input  logic [31:0] if_pc,
    input  logic        id_valid,
    input  logic        id_stall,
    input  logic        id_jump,
    input  logic [31:0] id_jump_target,
    input  logic        ex_branch_taken,
    input  logic [31:0] ex_branch_target,
    output pc_sel_e     pc_sel,
    output logic [31:0] pc_next
);

    always_comb begin
        pc_sel  = PC_SEQ;
        pc_next = if_pc + 32'd4;
        if (ex_branch_taken) begin
            pc_sel  = PC_BRANCH;
            pc_next = ex_branch_target;
        end else if (id_stall) begin
            pc_sel  = PC_HOLD;
            pc_next = if_pc;
        end else if (id_jump && id_valid) begin
            // a jump with nothing live in ID is stale and ignored
            pc_sel  = PC_JUMP;
            pc_next = id_jump_target;
        end
    end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch: PC register, IF/ID register, fetch address
// check and fetch/bubble performance counters.
module if_stage
    import mips_pkg::*;
#(
    parameter logic [31:0] TEXT_BASE  = mips_pkg::TEXT_BASE,
    parameter int          IMEM_WORDS = 1024,
    parameter int          CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst,
    output logic [31:0]      imem_addr,
    input  logic [31:0]      imem_rdata,
    input  logic             id_stall,
    input  logic             id_jump,
    input  logic [31:0]      id_jump_target,
    input  logic             ex_branch_taken,
    input  logic [31:0]      ex_branch_target,
    output logic [31:0]      IF_PC,
    output logic [31:0]      ID_PC,
    output logic [31:0]      ID_inst,
    output logic             ID_valid,
    output logic [31:0]      ID_pc4,
    output logic             addr_err,
    output logic [CNT_W-1:0] fetch_cnt,
    output logic [CNT_W-1:0] bubble_cnt
);

    localparam logic [32:0] TEXT_LO = {1'b0, TEXT_BASE};
    localparam logic [32:0] TEXT_HI = TEXT_LO + 33'(4 * IMEM_WORDS);

    logic [31:0]      if_pc_q, if_pc_d;
    if_id_t           if_id_q, if_id_d;
    logic             addr_err_q, addr_err_d;
    logic [CNT_W-1:0] fetch_cnt_q, fetch_cnt_d;
    logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;

    pc_sel_e     pc_sel;
    logic [31:0] pc_next;
    logic        fetch_ok;
    logic        load_valid;
    logic        load_bubble;

    pc_next_sel u_pc_next_sel (
        .if_pc            (if_pc_q),
        .id_valid         (if_id_q.valid),
        .id_stall         (id_stall),
        .id_jump          (id_jump),
        .id_jump_target   (id_jump_target),
        .ex_branch_taken  (ex_branch_taken),
        .ex_branch_target (ex_branch_target),
        .pc_sel           (pc_sel),
        .pc_next          (pc_next)
    );

    assign fetch_ok = (if_pc_q[1:0] == 2'b00)
                   && ({1'b0, if_pc_q} >= TEXT_LO)
                   && ({1'b0, if_pc_q} < TEXT_HI);

    always_comb begin
        if_pc_d     = if_pc_q;
        if_id_d     = if_id_q;
        addr_err_d  = addr_err_q;
        load_valid  = 1'b0;
        load_bubble = 1'b0;
        case (pc_sel)
            PC_BRANCH, PC_JUMP: begin
                if_pc_d       = pc_next;
                if_id_d.valid = 1'b0;
                if_id_d.inst  = NOP;
                load_bubble   = 1'b1;
            end
            PC_HOLD: begin
            end
            PC_SEQ: begin
                if_pc_d = pc_next;
                if (fetch_ok) begin
                    if_id_d.pc    = if_pc_q;
                    if_id_d.inst  = imem_rdata;
                    if_id_d.valid = 1'b1;
                    load_valid    = 1'b1;
                end else begin
                    if_id_d.valid = 1'b0;
                    if_id_d.inst  = NOP;
                    addr_err_d    = 1'b1;
                    load_bubble   = 1'b1;
                end
            end
        endcase
        fetch_cnt_d  = fetch_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
        if (load_valid && fetch_cnt_q != '1)
            fetch_cnt_d = fetch_cnt_q + 1'b1;
        if (load_bubble && bubble_cnt_q != '1)
            bubble_cnt_d = bubble_cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            if_pc_q      <= TEXT_BASE;
            if_id_q      <= '0;
            addr_err_q   <= 1'b0;
            fetch_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            if_pc_q      <= if_pc_d;
            if_id_q      <= if_id_d;
            addr_err_q   <= addr_err_d;
            fetch_cnt_q  <= fetch_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign imem_addr  = if_pc_q;
    assign IF_PC      = if_pc_q;
    assign ID_PC      = if_id_q.pc;
    assign ID_inst    = if_id_q.inst;
    assign ID_valid   = if_id_q.valid;
    assign ID_pc4     = if_id_q.pc + 32'd4;
    assign addr_err   = addr_err_q;
    assign fetch_cnt  = fetch_cnt_q;
    assign bubble_cnt = bubble_cnt_q;

endmodule

// File: tb/tb_if_stage.sv
// Scoreboard bench for if_stage: directed redirects, stalls and
// fetch-range errors with expected IF/ID state queued per cycle.
module tb_if_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        id_stall = 1'b0;
    logic        id_jump = 1'b0;
    logic [31:0] id_jump_target = '0;
    logic        ex_branch_taken = 1'b0;
    logic [31:0] ex_branch_target = '0;
    logic [31:0] IF_PC, ID_PC, ID_inst, ID_pc4;
    logic        ID_valid, addr_err;
    logic [31:0] fetch_cnt, bubble_cnt;

    if_stage dut (
        .clk              (clk),
        .rst              (rst),
        .imem_addr        (imem_addr),
        .imem_rdata       (imem_rdata),
        .id_stall         (id_stall),
        .id_jump          (id_jump),
        .id_jump_target   (id_jump_target),
        .ex_branch_taken  (ex_branch_taken),
        .ex_branch_target (ex_branch_target),
        .IF_PC            (IF_PC),
        .ID_PC            (ID_PC),
        .ID_inst          (ID_inst),
        .ID_valid         (ID_valid),
        .ID_pc4           (ID_pc4),
        .addr_err         (addr_err),
        .fetch_cnt        (fetch_cnt),
        .bubble_cnt       (bubble_cnt)
    );

    always #5 clk = ~clk;

    // word at 0x3000 is the reset-vector instruction; other words tag their address
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h3000) return 32'h2008_0005;
        return {16'hA5A5, a[15:0]};
    endfunction

    always_comb begin
        if (imem_addr[1:0] == 2'b00 && imem_addr >= 32'h3000 && imem_addr < 32'h4000)
            imem_rdata = mem_word(imem_addr);
        else
            imem_rdata = 32'hDEAD_BEEF;
    end

    typedef struct {
        int          cyc;
        logic [31:0] if_pc;
        logic [31:0] id_pc;
        logic        valid;
        logic [31:0] fetch;
        logic [31:0] bubble;
        logic        err;
    } exp_t;

    exp_t q[$];
    int   cycle = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   done = 1'b0;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    // monitor: compares each queued expectation on the falling edge of its cycle
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc <= cycle) begin
            exp_t e;
            e = q.pop_front();
            if (e.cyc < cycle) begin
                n_cmp++;
                n_bad++;
                $display("FAIL stale_entry: got cycle %0d expected cycle %0d", cycle, e.cyc);
            end else begin
                chk("IF_PC", IF_PC, e.if_pc);
                chk("imem_addr", imem_addr, e.if_pc);
                chk("ID_valid", {31'b0, ID_valid}, {31'b0, e.valid});
                if (e.valid) begin
                    chk("ID_PC", ID_PC, e.id_pc);
                    chk("ID_inst", ID_inst, mem_word(e.id_pc));
                    chk("ID_pc4", ID_pc4, e.id_pc + 32'd4);
                end else begin
                    chk("ID_inst_bubble", ID_inst, 32'h0);
                end
                chk("fetch_cnt", fetch_cnt, e.fetch);
                chk("bubble_cnt", bubble_cnt, e.bubble);
                chk("addr_err", {31'b0, addr_err}, {31'b0, e.err});
            end
        end
    end

    task automatic step(
        input logic        st,
        input logic        jp,
        input logic [31:0] jt,
        input logic        br,
        input logic [31:0] bt,
        input logic [31:0] e_if,
        input logic [31:0] e_id,
        input logic        e_v,
        input int          e_f,
        input int          e_b,
        input logic        e_err
    );
        exp_t e;
        id_stall         = st;
        id_jump          = jp;
        id_jump_target   = jt;
        ex_branch_taken  = br;
        ex_branch_target = bt;
        e.cyc    = cycle + 1;
        e.if_pc  = e_if;
        e.id_pc  = e_id;
        e.valid  = e_v;
        e.fetch  = 32'(e_f);
        e.bubble = 32'(e_b);
        e.err    = e_err;
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic reset_checks();
        chk("rst_IF_PC", IF_PC, 32'h3000);
        chk("rst_ID_PC", ID_PC, 32'h0);
        chk("rst_ID_inst", ID_inst, 32'h0);
        chk("rst_ID_valid", {31'b0, ID_valid}, 32'h0);
        chk("rst_addr_err", {31'b0, addr_err}, 32'h0);
        chk("rst_fetch_cnt", fetch_cnt, 32'h0);
        chk("rst_bubble_cnt", bubble_cnt, 32'h0);
    endtask

    initial begin
        #10;
        reset_checks();
        #8;
        rst = 1'b1;
        //   st jp jt            br bt            IF_PC         ID_PC         v  f   b  err
        step(0, 0, 32'h0,        0, 32'h0,        32'h3004, 32'h3000, 1, 1, 0, 0);
        step(0, 0, 32'h0,        0, 32'h0,        32'h3008, 32'h3004, 1, 2, 0, 0);
        step(0, 0, 32'h0,        0, 32'h0,        32'h300C, 32'h3008, 1, 3, 0, 0);
        step(1, 0, 32'h0,        0, 32'h0,        32'h300C, 32'h3008, 1, 3, 0, 0);
        step(1, 1, 32'h3080,     0, 32'h0,        32'h300C, 32'h3008, 1, 3, 0, 0);
        step(0, 0, 32'h0,        0, 32'h0,        32'h3010, 32'h300C, 1, 4, 0, 0);
        step(0, 0, 32'h0,        0, 32'h0,        32'h3014, 32'h3010, 1, 5, 0, 0);
        step(0, 1, 32'h3040,     0, 32'h0,        32'h3040, 32'h0,    0, 5, 1, 0);
        step(0, 0, 32'h0,        0, 32'h0,        32'h3044, 32'h3040, 1, 6, 1, 0);
        step(1, 1, 32'h3080,     1, 32'h3020,     32'h3020, 32'h0,    0, 6, 2, 0);
        step(0, 0, 32'h0,        0, 32'h0,        32'h3024, 32'h3020, 1, 7, 2, 0);
        step(0, 0, 32'h0,        1, 32'h3022,     32'h3022, 32'h0,    0, 7, 3, 0);
        step(0, 0, 32'h0,        0, 32'h0,        32'h3026, 32'h0,    0, 7, 4, 1);
        step(0, 0, 32'h0,        1, 32'h0000_0100, 32'h0100, 32'h0,   0, 7, 5, 1);
        step(0, 0, 32'h0,        0, 32'h0,        32'h0104, 32'h0,    0, 7, 6, 1);
        step(0, 0, 32'h0,        1, 32'h3030,     32'h3030, 32'h0,    0, 7, 7, 1);
        step(0, 1, 32'h3080,     0, 32'h0,        32'h3034, 32'h3030, 1, 8, 7, 1);
        step(0, 0, 32'h0,        0, 32'h0,        32'h3038, 32'h3034, 1, 9, 7, 1);
        step(0, 0, 32'h0,        1, 32'h3FFC,     32'h3FFC, 32'h0,    0, 9, 8, 1);
        step(0, 0, 32'h0,        0, 32'h0,        32'h4000, 32'h3FFC, 1, 10, 8, 1);
        step(0, 0, 32'h0,        0, 32'h0,        32'h4004, 32'h0,    0, 10, 9, 1);
        @(negedge clk);
        #1;
        id_stall = 1'b1;
        id_jump  = 1'b1;
        rst = 1'b0;
        #1;
        reset_checks();
        id_stall = 1'b0;
        id_jump  = 1'b0;
        #2;
        rst = 1'b1;
        step(0, 0, 32'h0,        0, 32'h0,        32'h3004, 32'h3000, 1, 1, 0, 0);
        step(0, 0, 32'h0,        0, 32'h0,        32'h3008, 32'h3004, 1, 2, 0, 0);
        repeat (3) @(negedge clk);
        if (q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        done = 1'b1;
    end

    initial begin
        fork
            wait (done);
            begin
                #20000;
                n_cmp++;
                n_bad++;
                $display("FAIL timeout: got no completion expected done by 20000ns");
            end
        join_any
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
